dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting between the pipeline's memory stage and the 128-bit line-oriented data memory.
- Acts as the initiator of the memory read/write/ready protocol:
  - issues one-cycle request pulses with a line-aligned address;
  - waits for the memory's one-cycle ready pulse;
  - stalls the pipeline on misses.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two, at least 2.
- INDEX_BITS, $clog2(NUM_LINES), line index width; derived, not overridden.
- TAG_BITS, 28-INDEX_BITS, tag width taken from addr[31:4+INDEX_BITS].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_read  in  1  load request, level; held until stall drops.
- cpu_write  in  1  store request, level; has priority if both are high.
- cpu_addr  in  32  byte address; bits [1:0] ignored, bits [3:2] select the word within the line.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid in the cycle where cpu_read=1 and stall=0.
- stall  out  1  high while a request is outstanding and not yet completed.
- mem_read  out  1  one-cycle line-read request pulse.
- mem_write  out  1  one-cycle line-write request pulse.
- mem_addr  out  32  line address; bits [3:0] always 0; stable from request until ready.
- mem_wdata  out  128  victim line; stable from request until ready.
- mem_ready  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  128  refill line; sampled only when mem_ready=1.

Behaviour:
- Reset:
  - state=IDLE; all valid and dirty bits cleared.
  - Outputs: stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
- Hit:
  - Condition: valid[idx] && tag[idx]==cpu_addr tag.
  - Resolved combinationally in IDLE; stall=0 in the same cycle, so hit latency is 0 extra cycles.
  - Load: cpu_rdata is the selected 32-bit word of the line.
  - Store: updates the selected word and sets dirty at the clock edge.
- States: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
- IDLE:
  - Request and miss: stall=1.
  - Victim valid and dirty → WB_REQ; otherwise → FILL_REQ.
- WB_REQ:
  - Drives mem_write=1 for exactly one cycle, with mem_addr={victim tag, idx, 4'b0} and mem_wdata=victim line.
  - → WB_WAIT.
- WB_WAIT:
  - Outputs held, mem_write=0.
  - On mem_ready: dirty[idx] cleared → FILL_REQ.
- FILL_REQ:
  - Drives mem_read=1 for exactly one cycle, with mem_addr={cpu_addr[31:4], 4'b0}.
  - → FILL_WAIT.
- FILL_WAIT:
  - Outputs held, mem_read=0.
  - On mem_ready: line=mem_rdata, tag written, valid=1, dirty=0 → IDLE.
  - The request then hits on the next cycle and completes as a normal hit.
- Request pulses:
  - mem_read and mem_write are never high together.
  - Each is never high on two consecutive cycles; memory re-triggers per sampled cycle.
- Spurious mem_ready in IDLE, WB_REQ or FILL_REQ is ignored.
- The CPU must hold cpu_addr, cpu_wdata, cpu_read and cpu_write stable while stall=1. Dropping the request mid-miss still finishes the refill.
- Reset asserted mid-miss:
  - Returns to IDLE immediately and invalidates all lines.
  - A memory ready arriving later is ignored.
- No request: stall=0 and no state change.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds 32-bit counters hit_count and miss_count, driven as outputs and cleared by reset.
  - hit_count increments on each request completed without entering a miss; it does not count the post-refill completion.
  - miss_count increments on each IDLE→WB_REQ/FILL_REQ transition.
  - Counters saturate at 32'hFFFFFFFF.
- Undefined: hit_count and miss_count are still present but tied to 0; no counter logic.

Decomposition:
- Package dcache_pkg:
  - state enum dcache_state_t {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT};
  - LINE_BITS=128, WORD_BITS=32, OFFSET_BITS=4.
- Sub-module dcache_line_store:
  - Holds the tag, valid, dirty and data arrays.
  - Combinational read by index; synchronous write port for word update and line fill; synchronous clear-all on reset.
- The FSM remains in dcache_controller.

Test Plan:
- Cold load, cpu_read addr 0x0000_0010:
  - one mem_read pulse with mem_addr=0x10;
  - memory returns line 0x44443333_22221111_... ;
  - stall falls in the cycle after ready; cpu_rdata=word[0].
- Store hit then reload:
  - write 0xDEADBEEF to 0x14 after the above fill;
  - stall stays 0; a subsequent load of 0x14 returns 0xDEADBEEF with no mem traffic.
- Dirty eviction:
  - load 0x14+NUM_LINES*16 (same index, new tag);
  - mem_write pulse, mem_addr=0x10, mem_wdata contains 0xDEADBEEF in word 1;
  - after ready, mem_read pulse to the new line address.
- Pulse discipline:
  - memory ready delayed 19 cycles;
  - mem_read is high exactly 1 cycle and mem_addr is stable for all 19 cycles;
  - extra ready pulses injected in IDLE cause no state change.
- Reset during FILL_WAIT:
  - stall=0, state IDLE, all lines invalid;
  - the late mem_ready is ignored;
  - the next load of a previously cached address misses.
- DCACHE_STATS_EN build:
  - sequence of 1 miss + 3 hits → miss_count=1, hit_count=3.
  - Non-macro build reads both counters as 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;
    localparam int LINE_BITS   = 128;
    localparam int WORD_BITS   = 32;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT
    } dcache_state_t;
endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: combinational read by index, synchronous writes.
// Only valid and dirty are cleared by reset; tag and data contents are don't-care while invalid.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int INDEX_BITS = $clog2(NUM_LINES),
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] i_idx,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic                  o_rd_valid,
    output logic                  o_rd_dirty,
    output logic [LINE_BITS-1:0]  o_rd_line,
    input  logic                  i_word_wr_en,
    input  logic [1:0]            i_word_sel,
    input  logic [WORD_BITS-1:0]  i_word_data,
    input  logic                  i_fill_en,
    input  logic [TAG_BITS-1:0]   i_fill_tag,
    input  logic [LINE_BITS-1:0]  i_fill_line,
    input  logic                  i_clean_en
);
    logic [TAG_BITS-1:0]  r_tag   [NUM_LINES];
    logic [LINE_BITS-1:0] r_data  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    assign o_rd_tag   = r_tag[i_idx];
    assign o_rd_valid = r_valid[i_idx];
    assign o_rd_dirty = r_dirty[i_idx];
    assign o_rd_line  = r_data[i_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_clean_en) begin
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_wr_en) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_idx]  <= i_fill_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_word_wr_en) begin
            r_data[i_idx][{i_word_sel, 5'b0} +: WORD_BITS] <= i_word_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache with a one-cycle-pulse line memory interface.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters; otherwise they read as zero.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_wdata,
    output logic [WORD_BITS-1:0] cpu_rdata,
    output logic                 stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = 28 - INDEX_BITS;

    dcache_state_t        r_state, w_next;
    logic [27:0]          r_req_line;
    logic [31:0]          r_mem_addr;
    logic [LINE_BITS-1:0] r_mem_wdata;

    logic                  w_req, w_hit, w_victim_dirty;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_cpu_tag, w_rd_tag;
    logic                  w_rd_valid, w_rd_dirty;
    logic [LINE_BITS-1:0]  w_rd_line;
    logic                  w_word_wr_en, w_fill_en, w_clean_en;
    logic                  w_unused;

    assign w_unused       = &{1'b0, cpu_addr[1:0]};
    assign w_req          = cpu_read | cpu_write;
    assign w_cpu_tag      = cpu_addr[31:OFFSET_BITS+INDEX_BITS];
    // Outside IDLE the miss is serviced for the latched address, so a dropped request still refills.
    assign w_idx          = (r_state == IDLE) ? cpu_addr[OFFSET_BITS +: INDEX_BITS]
                                              : r_req_line[INDEX_BITS-1:0];
    assign w_hit          = w_rd_valid && (w_rd_tag == w_cpu_tag);
    assign w_victim_dirty = w_rd_valid && w_rd_dirty;

    dcache_line_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .i_idx       (w_idx),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_dirty  (w_rd_dirty),
        .o_rd_line   (w_rd_line),
        .i_word_wr_en(w_word_wr_en),
        .i_word_sel  (cpu_addr[3:2]),
        .i_word_data (cpu_wdata),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (r_req_line[27:INDEX_BITS]),
        .i_fill_line (mem_rdata),
        .i_clean_en  (w_clean_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_line  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req && !w_hit) begin
                r_req_line <= cpu_addr[31:4];
                if (w_victim_dirty) begin
                    r_mem_addr  <= {w_rd_tag, w_idx, 4'b0};
                    r_mem_wdata <= w_rd_line;
                end else begin
                    r_mem_addr <= {cpu_addr[31:4], 4'b0};
                end
            end else if (r_state == WB_WAIT && mem_ready) begin
                r_mem_addr <= {r_req_line, 4'b0};
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        stall        = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        w_word_wr_en = 1'b0;
        w_fill_en    = 1'b0;
        w_clean_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_word_wr_en = cpu_write;
                    end else begin
                        stall  = 1'b1;
                        w_next = w_victim_dirty ? WB_REQ : FILL_REQ;
                    end
                end
            end
            WB_REQ: begin
                stall     = 1'b1;
                mem_write = 1'b1;
                w_next    = WB_WAIT;
            end
            WB_WAIT: begin
                stall = 1'b1;
                if (mem_ready) begin
                    w_clean_en = 1'b1;
                    w_next     = FILL_REQ;
                end
            end
            FILL_REQ: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                w_next   = FILL_WAIT;
            end
            FILL_WAIT: begin
                stall = 1'b1;
                if (mem_ready) begin
                    w_fill_en = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rdata = (r_state == IDLE && cpu_read && w_hit)
                       ? w_rd_line[{cpu_addr[3:2], 5'b0} +: WORD_BITS] : '0;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;
    logic        r_post_fill;

    // The completion right after a refill belongs to the miss, not to the hit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_post_fill  <= 1'b0;
        end else begin
            r_post_fill <= (r_state == FILL_WAIT) && mem_ready;
            if (r_state == IDLE && w_req && w_hit && !r_post_fill && r_hit_count != 32'hFFFF_FFFF)
                r_hit_count <= r_hit_count + 32'd1;
            if (r_state == IDLE && w_req && !w_hit && r_miss_count != 32'hFFFF_FFFF)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench: CPU-side access tasks, a latency-programmable line memory and request/load scoreboards.
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         stall, mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic [31:0]  hit_count, miss_count;

    dcache_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } req_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_cyc = -10;
    int mem_lat = 2;
    int pulses = 0;
    int rd_pulses = 0;
    logic inj_ready = 1'b0;
    logic pend = 1'b0, pend_wr = 1'b0, pend_abandon = 1'b0, prev_req = 1'b0;
    int pend_cnt = 0;
    logic [31:0]  pend_addr = '0;
    logic [127:0] pend_wdata = '0;
    logic [127:0] mem_arr [logic [31:0]];
    req_t         req_q [$];
    logic [31:0]  rd_q [$];

    localparam logic [127:0] L10 = 128'h44443333_22221111_88887777_66665555;

    function automatic logic [127:0] line_pat(input logic [31:0] a);
        return {a + 32'h3000_0003, a + 32'h2000_0002, a + 32'h1000_0001, a ^ 32'h0F0F_0000};
    endfunction

    function automatic logic [127:0] mem_get(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return line_pat(a);
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [31:0] a);
        logic [1:0] w;
        w = a[3:2];
        return line[w*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic wr, input logic [31:0] a, input logic [127:0] wd);
        req_t r;
        r.wr = wr;
        r.addr = a;
        r.wdata = wd;
        req_q.push_back(r);
    endtask

    always @(posedge clk) cyc++;

    // Line memory: answers each sampled request pulse with one ready pulse mem_lat cycles later.
    always @(negedge clk) begin
        req_t e;
        mem_ready = inj_ready;
        if (pend) begin
            if (!pend_abandon) chk("addr_hold", mem_addr, pend_addr);
            if (pend_cnt == 0) begin
                mem_ready = 1'b1;
                ready_cyc = cyc;
                if (pend_wr) mem_arr[pend_addr] = pend_wdata;
                else mem_rdata = mem_get(pend_addr);
                pend = 1'b0;
                pend_abandon = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (mem_read || mem_write) begin
            chk("req_exclusive", mem_read & mem_write, 1'b0);
            chk("req_single_cycle", prev_req, 1'b0);
            chk("req_expected", req_q.size() != 0, 1'b1);
            if (req_q.size() != 0) begin
                e = req_q.pop_front();
                chk("req_kind", mem_write, e.wr);
                chk("req_addr", mem_addr, e.addr);
                if (e.wr) chk("req_wdata", mem_wdata, e.wdata);
            end
            pulses++;
            if (mem_read) rd_pulses++;
            pend = 1'b1;
            pend_wr = mem_write;
            pend_addr = mem_addr;
            pend_wdata = mem_wdata;
            pend_cnt = mem_lat - 1;
        end
        prev_req = mem_read | mem_write;
    end

    task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic exp_hit, input logic [31:0] exp_rd, output int waited);
        logic first_stall;
        logic [31:0] e;
        int n;
        @(posedge clk); #1;
        cpu_read = !wr;
        cpu_write = wr;
        cpu_addr = a;
        cpu_wdata = wd;
        if (!wr) rd_q.push_back(exp_rd);
        n = 0;
        @(negedge clk);
        first_stall = stall;
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        chk("access_done", n < 200, 1'b1);
        chk("hit_or_miss", first_stall, !exp_hit);
        if (!exp_hit) chk("stall_fall", 32'(cyc), 32'(ready_cyc + 1));
        if (!wr) begin
            e = rd_q.pop_front();
            chk("load_data", cpu_rdata, e);
        end
        @(posedge clk); #1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        int w;
        int p0;
        logic [127:0] victim;
        mem_arr[32'h10] = L10;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);

        // Cold load, then three hits including a store.
        push_req(1'b0, 32'h10, '0);
        cpu_access(1'b0, 32'h10, '0, 1'b0, word_of(L10, 32'h10), w);
        p0 = pulses;
        cpu_access(1'b1, 32'h14, 32'hDEAD_BEEF, 1'b1, '0, w);
        cpu_access(1'b0, 32'h14, '0, 1'b1, 32'hDEAD_BEEF, w);
        cpu_access(1'b0, 32'h1C, '0, 1'b1, word_of(L10, 32'h1C), w);
        chk("hits_no_traffic", pulses, p0);
`ifdef DCACHE_STATS_EN
        chk("stats_hits", hit_count, 32'd3);
        chk("stats_misses", miss_count, 32'd1);
`else
        chk("stats_hits_tied", hit_count, 32'd0);
        chk("stats_misses_tied", miss_count, 32'd0);
`endif

        // Dirty eviction of line 0x10 by a conflicting tag.
        victim = L10;
        victim[63:32] = 32'hDEAD_BEEF;
        push_req(1'b1, 32'h10, victim);
        push_req(1'b0, 32'h410, '0);
        cpu_access(1'b0, 32'h414, '0, 1'b0, word_of(line_pat(32'h410), 32'h414), w);
        chk("wb_stored", mem_get(32'h10), victim);

        // Long memory latency: one pulse, address held throughout.
        mem_lat = 19;
        p0 = rd_pulses;
        push_req(1'b0, 32'h820, '0);
        cpu_access(1'b0, 32'h828, '0, 1'b0, word_of(line_pat(32'h820), 32'h828), w);
        chk("slow_single_pulse", rd_pulses - p0, 1);
        chk("slow_wait_len", w >= 19, 1'b1);
        mem_lat = 2;

        // Stray ready pulses with no miss outstanding.
        p0 = pulses;
        @(posedge clk); #1 inj_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_stall", stall, 1'b0);
        end
        @(posedge clk); #1 inj_ready = 1'b0;
        cpu_access(1'b0, 32'h820, '0, 1'b1, word_of(line_pat(32'h820), 32'h820), w);
        chk("stray_no_traffic", pulses, p0);

        // Reset while the fill is outstanding.
        mem_lat = 10;
        push_req(1'b0, 32'hC30, '0);
        @(posedge clk); #1;
        cpu_read = 1'b1;
        cpu_addr = 32'hC30;
        repeat (4) @(negedge clk);
        chk("fill_pending_stall", stall, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        pend_abandon = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_mem_read", mem_read, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        p0 = pulses;
        repeat (12) begin
            @(negedge clk);
            chk("late_ready_ignored", {stall, mem_read, mem_write}, 3'b000);
        end
        chk("late_ready_sent", pend, 1'b0);
        chk("late_no_traffic", pulses, p0);
        mem_lat = 2;
        push_req(1'b0, 32'h820, '0);
        cpu_access(1'b0, 32'h824, '0, 1'b0, word_of(line_pat(32'h820), 32'h824), w);

        repeat (2) @(posedge clk);
        chk("req_q_drained", req_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
